// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: shared FSM states, register-select addresses and access-direction check
package lcd_timing_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, DONE} state_t;
  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STAT   = 2'd1;
  localparam logic [1:0] ADDR_DATA_W = 2'd2;
  localparam logic [1:0] ADDR_DATA_R = 2'd3;
  // even addresses are write registers, odd addresses are read registers
  function automatic logic addr_ok(input logic wr, input logic [1:0] a);
    return wr ? !a[0] : a[0];
  endfunction
endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable 8-bit down-counter that stops at zero; ports clk/reset, load+value in, count+zero out
module lcd_delay_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  output logic [7:0] count,
  output logic       zero
);
  assign zero = count == 8'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (!zero) count <= count - 8'd1;
endmodule

// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: Avalon-MM slave driving an HD44780-style LCD bus; ports: clk/reset, Avalon address/read/write/writedata/readdata/waitrequest, LCD_E/RS/RW strobes, LCD_data_out/oe/in
module lcd_timing_ctrl
  import lcd_timing_pkg::*;
#(
  parameter int T_SETUP   = 2,
  parameter int T_EH      = 4,
  parameter int T_HOLD    = 2,
  parameter int BUS_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  input  logic [7:0] LCD_data_in
);
  localparam logic [7:0] LD_S = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_E = 8'(T_EH - 1);
  localparam logic [7:0] LD_H = 8'(T_HOLD - 1);
  state_t state, next;
  logic [1:0] addr_q;
  logic       wr_q;
  logic [7:0] data_q;
  logic       nib_q;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       zero;
  logic       req;
  logic       last_nib;
  logic       xfer;
  assign req      = read | write;
  assign last_nib = BUS_WIDTH == 8 || nib_q;
  lcd_delay_cnt u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .value(load_val),
    .count(count),
    .zero (zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // each phase loads its length minus one so the phase ends on the cycle the counter reads zero
  always_comb begin
    next     = state;
    load     = 1'b0;
    load_val = LD_S;
    case (state)
      IDLE:  if (req) begin
        next = addr_ok(write, address) ? SETUP : DONE;
        load = 1'b1;
      end
      SETUP: if (zero) begin
        next     = EHIGH;
        load     = 1'b1;
        load_val = LD_E;
      end
      EHIGH: if (zero) begin
        next     = HOLD;
        load     = 1'b1;
        load_val = LD_H;
      end
      HOLD:  if (zero) begin
        next = last_nib ? DONE : SETUP;
        load = !last_nib;
      end
      default: next = IDLE;
    endcase
  end
  always_comb begin
    xfer         = state == SETUP || state == EHIGH || state == HOLD;
    LCD_E        = state == EHIGH;
    LCD_RS       = xfer & addr_q[1];
    LCD_RW       = xfer & !wr_q;
    LCD_data_oe  = xfer & wr_q;
    LCD_data_out = !LCD_data_oe ? 8'h00 :
                   BUS_WIDTH == 8 ? data_q :
                   {nib_q ? data_q[3:0] : data_q[7:4], 4'h0};
    waitrequest  = req && state != DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      nib_q    <= 1'b0;
      readdata <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q   <= address;
        wr_q     <= write;
        data_q   <= writedata;
        nib_q    <= 1'b0;
        readdata <= '0;
      end
      if (state == HOLD && zero && !last_nib) nib_q <= 1'b1;
      if (state == EHIGH && zero && !wr_q)
        readdata <= BUS_WIDTH == 8 ? LCD_data_in :
                    nib_q ? {readdata[7:4], LCD_data_in[7:4]} : {LCD_data_in[7:4], 4'h0};
    end
endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// tb_lcd_timing_ctrl: directed bench for 8-bit and 4-bit instances with a readdata/latency scoreboard
module tb_lcd_timing_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] address = '0;
  logic [7:0] writedata = '0;
  logic [7:0] din = '0;
  logic rd8 = 1'b0, wr8 = 1'b0, rd4 = 1'b0, wr4 = 1'b0;
  logic sel4 = 1'b0;
  logic [7:0] rdd8, rdd4, do8, do4, rdd, dout;
  logic wt8, wt4, e8, e4, rs8, rs4, rw8, rw4, oe8, oe4;
  logic wt, e, rs, rw, oe;
  int total = 0;
  int bad = 0;
  logic [7:0] q_rd[$];
  int q_lat[$];

  lcd_timing_ctrl #(.T_SETUP(2), .T_EH(4), .T_HOLD(2), .BUS_WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .address(address), .read(rd8), .write(wr8),
    .writedata(writedata), .readdata(rdd8), .waitrequest(wt8),
    .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8),
    .LCD_data_out(do8), .LCD_data_oe(oe8), .LCD_data_in(din)
  );
  lcd_timing_ctrl #(.T_SETUP(2), .T_EH(4), .T_HOLD(2), .BUS_WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .address(address), .read(rd4), .write(wr4),
    .writedata(writedata), .readdata(rdd4), .waitrequest(wt4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4),
    .LCD_data_out(do4), .LCD_data_oe(oe4), .LCD_data_in(din)
  );

  always_comb begin
    wt   = sel4 ? wt4 : wt8;
    e    = sel4 ? e4 : e8;
    rs   = sel4 ? rs4 : rs8;
    rw   = sel4 ? rw4 : rw8;
    oe   = sel4 ? oe4 : oe8;
    dout = sel4 ? do4 : do8;
    rdd  = sel4 ? rdd4 : rdd8;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // one Avalon transfer; expected waveform derives from a 2/4/2 phase pattern of 8 cycles per nibble
  task automatic run(input int bw, input logic rd, input logic wr, input logic [1:0] a,
                     input logic [7:0] wd, input logic [7:0] d1, input logic [7:0] d2);
    int n;
    int lat;
    bit ok;
    bit done;
    logic [7:0] exp_rd;
    logic [7:0] got_rd;
    n      = bw == 4 ? 2 : 1;
    ok     = wr ? !a[0] : a[0];
    lat    = ok ? 1 + n * 8 : 1;
    exp_rd = (!ok || wr) ? 8'h00 : bw == 8 ? d1 : {d1[7:4], d2[7:4]};
    done   = 1'b0;
    @(negedge clk);
    sel4 = bw == 4;
    address = a;
    writedata = wd;
    din = d1;
    if (bw == 4) begin rd4 = rd; wr4 = wr; end
    else begin rd8 = rd; wr8 = wr; end
    q_rd.push_back(exp_rd);
    q_lat.push_back(lat);
    #1 chk($sformatf("wait c0 a%0d", a), wt, 1);
    for (int c = 1; c <= lat + 3 && !done; c++) begin
      @(negedge clk);
      if (!wt) begin
        chk($sformatf("latency a%0d w%0d", a, wr), c, q_lat.pop_front());
        got_rd = q_rd.pop_front();
        if (!wr) chk($sformatf("readdata a%0d", a), rdd, got_rd);
        chk("E at done", e, 0);
        done = 1'b1;
        rd8 = 0; wr8 = 0; rd4 = 0; wr4 = 0;
      end else if (ok && c < lat) begin
        int k;
        int nb;
        k  = (c - 1) % 8;
        nb = (c - 1) / 8;
        chk($sformatf("E c%0d", c), e, k >= 2 && k < 6);
        chk($sformatf("RS c%0d", c), rs, a[1]);
        chk($sformatf("RW c%0d", c), rw, !wr);
        chk($sformatf("oe c%0d", c), oe, wr);
        if (wr) chk($sformatf("data c%0d", c), dout,
                    bw == 8 ? wd : {nb != 0 ? wd[3:0] : wd[7:4], 4'h0});
        if (c == 8) din = d2;
      end
    end
    chk("done seen", done, 1);
    if (!done) begin
      void'(q_rd.pop_front());
      void'(q_lat.pop_front());
    end
    rd8 = 0; wr8 = 0; rd4 = 0; wr4 = 0;
    @(negedge clk);
    chk("idle E", e, 0);
    chk("idle oe", oe, 0);
  endtask

  initial begin
    int ecnt;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel4 = s[0];
      #1;
      chk("rst E", e, 0);
      chk("rst RS", rs, 0);
      chk("rst RW", rw, 0);
      chk("rst oe", oe, 0);
      chk("rst data", dout, 0);
      chk("rst readdata", rdd, 0);
      chk("rst wait", wt, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    run(8, 0, 1, 2'd0, 8'h38, 8'h00, 8'h00);
    run(8, 1, 0, 2'd1, 8'h00, 8'h80, 8'h80);
    run(8, 1, 0, 2'd3, 8'h00, 8'h5A, 8'h5A);
    run(4, 0, 1, 2'd2, 8'hA5, 8'h00, 8'h00);
    run(4, 1, 0, 2'd3, 8'h00, 8'hC3, 8'h7E);
    run(8, 0, 1, 2'd1, 8'h99, 8'h00, 8'h00);
    run(8, 1, 0, 2'd0, 8'h00, 8'hFF, 8'hFF);
    run(8, 1, 1, 2'd2, 8'h41, 8'h00, 8'h00);
    run(4, 0, 1, 2'd3, 8'h12, 8'h00, 8'h00);
    // strobe released after acceptance: the panel still sees one full E pulse
    @(negedge clk);
    sel4 = 1'b0;
    address = 2'd2;
    writedata = 8'h55;
    wr8 = 1'b1;
    @(negedge clk);
    wr8 = 1'b0;
    ecnt = 0;
    repeat (12) @(negedge clk) if (e) ecnt++;
    chk("drop E pulse width", ecnt, 4);
    // reset during the E pulse of a write
    @(negedge clk);
    address = 2'd0;
    writedata = 8'h38;
    wr8 = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre-reset E", e, 1);
    chk("pre-reset oe", oe, 1);
    #2 reset = 1'b1;
    #1;
    chk("async rst E", e, 0);
    chk("async rst oe", oe, 0);
    wr8 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run(8, 0, 1, 2'd0, 8'h01, 8'h00, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
